// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared types and constants for the debug/load controller
// Holds the controller state encoding, the UART command bytes and the
// word-assembly geometry used by debug_ctrl and word_assembler.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_LEN_HI,
    ST_LD_LEN_LO,
    ST_LD_DATA,
    ST_RUN,
    ST_STEP
  } state_t;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_PAUSE = 8'h50;  // 'P'

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - MSB-first byte-to-32-bit-word assembler
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_clear          discard any partial word and restart at byte 0
//   i_valid, i_byte  incoming byte strobe and data
//   o_word_valid     high in the cycle the final byte of a word arrives
//   o_word           assembled word (valid with o_word_valid)
module word_assembler
  import debug_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  // Only the first three bytes need storing; the fourth is taken straight
  // from i_byte so the word is available in the same cycle.
  logic [23:0]           shift_q, shift_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (i_clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (i_valid) begin
      shift_d = {shift_q[15:0], i_byte};
      cnt_d   = cnt_q + BYTE_CNT_W'(1);  // wraps back to 0 after the last byte
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_word_valid = i_valid && !i_clear && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign o_word       = {shift_q, i_byte};

endmodule

// File: rtl/debug_ctrl.sv
// rtl/debug_ctrl.sv - UART-driven instruction loader and run/step/pause controller
// Ports:
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_rx_data/i_rx_valid received UART byte and its one-cycle strobe
//   i_halt               pipeline retired a HALT (level)
//   o_imem_*             registered instruction-memory write port
//   o_stall              freezes PC and pipeline registers
//   o_cpu_reset          one-cycle pipeline reset pulse after a completed load
//   o_busy               load in progress
//   o_load_overflow      sticky: last load ran past IMEM_WORDS
//   o_cycle_count        unstalled cycles since the last o_cpu_reset
module debug_ctrl
  import debug_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_halt,
  output logic                  o_imem_write_en,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [31:0]           o_imem_data,
  output logic                  o_stall,
  output logic                  o_cpu_reset,
  output logic                  o_busy,
  output logic                  o_load_overflow,
  output logic [31:0]           o_cycle_count
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  state_t                state_q;
  logic [15:0]           len_q;
  logic [15:0]           idx_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic                  done_q;     // final word taken; pipeline reset follows the write strobe
  logic                  cpu_reset_q;
  logic                  ovf_q;
  logic [31:0]           cc_q;

  logic        asm_clear;
  logic        asm_valid;
  logic        word_valid;
  logic [31:0] word;
  logic        run_go;
  logic        in_range;

  // The length LSB is the byte that moves us into LD_DATA, so the
  // assembler is flushed right then.
  assign asm_clear = i_rx_valid && (state_q == ST_LD_LEN_LO);
  assign asm_valid = i_rx_valid && (state_q == ST_LD_DATA);

  word_assembler u_asm (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (asm_clear),
    .i_valid      (asm_valid),
    .i_byte       (i_rx_data),
    .o_word_valid (word_valid),
    .o_word       (word)
  );

  // Halt and pause must freeze the pipeline in the very cycle they appear,
  // so the RUN unstall is qualified combinationally.
  assign run_go   = (state_q == ST_RUN) && !i_halt &&
                    !(i_rx_valid && (i_rx_data == CMD_PAUSE));
  assign o_stall  = !(run_go || (state_q == ST_STEP));
  assign in_range = 32'(idx_q) < IMEM_LIMIT;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      cpu_reset_q <= 1'b0;
      ovf_q       <= 1'b0;
      cc_q        <= '0;
    end else begin
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      cpu_reset_q <= done_q;

      if (done_q)        cc_q <= '0;
      else if (!o_stall) cc_q <= cc_q + 32'd1;

      case (state_q)
        ST_IDLE: begin
          if (i_rx_valid) begin
            if (i_rx_data == CMD_LOAD) begin
              state_q <= ST_LD_LEN_HI;
              ovf_q   <= 1'b0;
            end else if (i_rx_data == CMD_RUN && !i_halt) begin
              state_q <= ST_RUN;
            end else if (i_rx_data == CMD_STEP && !i_halt) begin
              state_q <= ST_STEP;
            end
          end
        end
        ST_LD_LEN_HI: begin
          if (i_rx_valid) begin
            len_q[15:8] <= i_rx_data;
            state_q     <= ST_LD_LEN_LO;
          end
        end
        ST_LD_LEN_LO: begin
          if (i_rx_valid) begin
            len_q[7:0] <= i_rx_data;
            idx_q      <= '0;
            state_q    <= ({len_q[15:8], i_rx_data} == 16'd0) ? ST_IDLE : ST_LD_DATA;
          end
        end
        ST_LD_DATA: begin
          if (word_valid) begin
            if (in_range) begin
              we_q   <= 1'b1;
              addr_q <= ADDR_WIDTH'({idx_q, 2'b00});
              data_q <= word;
            end else begin
              ovf_q <= 1'b1;
            end
            idx_q <= idx_q + 16'd1;
            if (idx_q == len_q - 16'd1) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (i_halt || (i_rx_valid && i_rx_data == CMD_PAUSE)) state_q <= ST_IDLE;
        end
        ST_STEP: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_imem_write_en = we_q;
  assign o_imem_addr     = addr_q;
  assign o_imem_data     = data_q;
  assign o_cpu_reset     = cpu_reset_q;
  assign o_load_overflow = ovf_q;
  assign o_cycle_count   = cc_q;
  assign o_busy          = (state_q == ST_LD_LEN_HI) || (state_q == ST_LD_LEN_LO) ||
                           (state_q == ST_LD_DATA);

endmodule

// File: tb/tb_debug_ctrl.sv
// tb/tb_debug_ctrl.sv - self-checking bench for debug_ctrl
module tb_debug_ctrl;

  localparam int IMEM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        halt = 1'b0;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        cpu_reset;
  logic        busy;
  logic        ovf;
  logic [31:0] cc;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] obs_writes[$];
  logic [63:0] exp_writes[$];
  int          cpu_reset_cnt = 0;
  int          unstall_cnt   = 0;

  int          base_rst;
  int          base_unstall;
  int          nwords;
  logic [31:0] w;

  debug_ctrl #(.IMEM_WORDS(IMEM), .ADDR_WIDTH(32)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_rx_data       (rx_data),
    .i_rx_valid      (rx_valid),
    .i_halt          (halt),
    .o_imem_write_en (we),
    .o_imem_addr     (addr),
    .o_imem_data     (wdata),
    .o_stall         (stall),
    .o_cpu_reset     (cpu_reset),
    .o_busy          (busy),
    .o_load_overflow (ovf),
    .o_cycle_count   (cc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (we) obs_writes.push_back({addr, wdata});
      if (cpu_reset) cpu_reset_cnt++;
      if (!stall) unstall_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] v);
    for (int b = 0; b < 4; b++) send_byte(v[31-8*b -: 8]);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, 64'(obs_writes.size()), 64'(exp_writes.size()));
    for (int i = 0; i < exp_writes.size() && i < obs_writes.size(); i++)
      check({tag, "_entry"}, obs_writes[i], exp_writes[i]);
  endtask

  initial begin
    // reset and quiet idle
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_stall", 64'(stall), 64'd1);
    check("rst_we", 64'(we), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_data", 64'(wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd0);
    tick(20);
    check("idle_cc", 64'(cc), 64'd0);
    check("idle_stall", 64'(stall), 64'd1);
    check("idle_unstall", 64'(unstall_cnt), 64'd0);
    check("idle_writes", 64'(obs_writes.size()), 64'd0);

    // directed two-word load, back-to-back bytes
    obs_writes.delete();
    exp_writes.delete();
    base_rst = cpu_reset_cnt;
    send_byte(8'h4C);
    check("load_busy", 64'(busy), 64'd1);
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(32'h2008_0005);
    check("w0_we", 64'(we), 64'd1);
    check("w0_addr", 64'(addr), 64'h0);
    check("w0_data", 64'(wdata), 64'h2008_0005);
    send_word(32'hAC01_0004);
    check("w1_we", 64'(we), 64'd1);
    check("w1_addr", 64'(addr), 64'h4);
    check("w1_data", 64'(wdata), 64'hAC01_0004);
    check("w1_busy", 64'(busy), 64'd0);
    check("w1_no_cpu_reset_yet", 64'(cpu_reset), 64'd0);
    tick(1);
    check("after_we_low", 64'(we), 64'd0);
    check("cpu_reset_pulse", 64'(cpu_reset), 64'd1);
    check("cpu_reset_cc", 64'(cc), 64'd0);
    tick(1);
    check("cpu_reset_end", 64'(cpu_reset), 64'd0);
    tick(2);
    exp_writes.push_back({32'h0, 32'h2008_0005});
    exp_writes.push_back({32'h4, 32'hAC01_0004});
    compare_writes("load2");
    check("load2_resets", 64'(cpu_reset_cnt - base_rst), 64'd1);

    // zero-length load
    obs_writes.delete();
    base_rst = cpu_reset_cnt;
    send_byte(8'h4C);
    send_byte(8'h00);
    send_byte(8'h00);
    check("n0_busy", 64'(busy), 64'd0);
    tick(4);
    check("n0_writes", 64'(obs_writes.size()), 64'd0);
    check("n0_resets", 64'(cpu_reset_cnt - base_rst), 64'd0);
    check("n0_stall", 64'(stall), 64'd1);

    // overflow: one more word than memory holds
    obs_writes.delete();
    exp_writes.delete();
    send_byte(8'h4C);
    send_byte(8'h00);
    send_byte(8'(IMEM + 1));
    for (int i = 0; i < IMEM + 1; i++) begin
      w = $urandom;
      send_word(w);
      if (i < IMEM) exp_writes.push_back({32'(i * 4), w});
    end
    tick(3);
    compare_writes("ovf");
    check("ovf_set", 64'(ovf), 64'd1);
    send_byte(8'h4C);
    check("ovf_cleared", 64'(ovf), 64'd0);
    base_rst = cpu_reset_cnt;
    send_byte(8'h00);
    send_byte(8'h00);
    tick(3);
    check("ovf_exit_busy", 64'(busy), 64'd0);
    check("ovf_exit_resets", 64'(cpu_reset_cnt - base_rst), 64'd0);

    // three single steps; a byte arriving during STEP is dropped
    base_unstall = unstall_cnt;
    for (int s = 0; s < 3; s++) begin
      send_byte(8'h53);
      check("step_window", 64'(stall), 64'd0);
      if (s == 1) send_byte(8'h52);
      else tick(1);
      check("step_closed", 64'(stall), 64'd1);
      tick(2);
    end
    check("step_unstalled", 64'(unstall_cnt - base_unstall), 64'd3);
    check("step_cc", 64'(cc), 64'd3);

    // one-word load clears the cycle counter
    send_byte(8'h4C);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'h0BAD_F00D);
    tick(3);
    check("reload_cc", 64'(cc), 64'd0);

    // run for ten cycles, then halt
    send_byte(8'h52);
    check("run_unstall", 64'(stall), 64'd0);
    tick(10);
    halt = 1'b1;
    #1;
    check("halt_same_cycle", 64'(stall), 64'd1);
    tick(1);
    check("halt_cc", 64'(cc), 64'd10);
    check("halt_idle_stall", 64'(stall), 64'd1);
    check("halt_idle_busy", 64'(busy), 64'd0);
    send_byte(8'h52);
    check("run_ignored_halt", 64'(stall), 64'd1);
    tick(2);
    check("run_ignored_cc", 64'(cc), 64'd10);
    halt = 1'b0;
    tick(2);
    check("still_idle", 64'(stall), 64'd1);

    // run then pause
    send_byte(8'h52);
    tick(3);
    check("pre_pause_cc", 64'(cc), 64'd13);
    rx_data  = 8'h50;
    rx_valid = 1'b1;
    #1;
    check("pause_same_cycle", 64'(stall), 64'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("pause_stall", 64'(stall), 64'd1);
    check("pause_cc", 64'(cc), 64'd13);

    // randomized loads with random inter-byte gaps (including none)
    for (int t = 0; t < 6; t++) begin
      nwords = $urandom_range(0, IMEM + 2);
      obs_writes.delete();
      exp_writes.delete();
      base_rst = cpu_reset_cnt;
      send_byte(8'h4C);
      send_byte(8'h00);
      send_byte(8'(nwords));
      for (int i = 0; i < nwords; i++) begin
        w = $urandom;
        for (int b = 0; b < 4; b++) begin
          send_byte(w[31-8*b -: 8]);
          tick($urandom_range(0, 2));
        end
        if (i < IMEM) exp_writes.push_back({32'(i * 4), w});
      end
      tick(3);
      compare_writes("rand");
      check("rand_ovf", 64'(ovf), 64'(nwords > IMEM));
      check("rand_resets", 64'(cpu_reset_cnt - base_rst), 64'(nwords > 0));
      check("rand_busy", 64'(busy), 64'd0);
    end

    // asynchronous reset in the middle of a word
    obs_writes.delete();
    send_byte(8'h4C);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_stall", 64'(stall), 64'd1);
    check("arst_cc", 64'(cc), 64'd0);
    check("arst_addr", 64'(addr), 64'd0);
    check("arst_ovf", 64'(ovf), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(4);
    check("arst_no_write", 64'(obs_writes.size()), 64'd0);
    exp_writes.delete();
    send_byte(8'h4C);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'h1122_3344);
    tick(3);
    exp_writes.push_back({32'h0, 32'h1122_3344});
    compare_writes("post_arst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_ctrl.md
# debug_ctrl

Debug/load controller that sequences the instruction-fetch stage. It receives a byte stream from the UART receiver and assembles 32-bit words. It writes those words into instruction memory through its write port, then gates the pipeline with the stall line in run, single-step or idle mode. It sits between the UART RX and the IF stage: it drives the instruction-memory write port, the IF/pipeline stall and the CPU reset, and counts executed cycles for debug readout.

## Interface
- IMEM_WORDS, 256, instruction-memory depth in 32-bit words; writes beyond it are dropped
- ADDR_WIDTH, 32, width of the instruction-memory byte address
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- i_halt  in  1  pipeline has retired a HALT instruction (level)
- o_imem_write_en  out  1  instruction-memory write strobe
- o_imem_addr  out  ADDR_WIDTH  instruction-memory byte address (word index × 4)
- o_imem_data  out  32  instruction word to write
- o_stall  out  1  freezes PC and pipeline registers when 1
- o_cpu_reset  out  1  one-cycle pulse that returns PC and pipeline to reset state
- o_busy  out  1  load in progress
- o_load_overflow  out  1  sticky: load exceeded IMEM_WORDS
- o_cycle_count  out  32  unstalled cycles since last o_cpu_reset

## Operation
- Command bytes: 0x4C 'L' load, 0x52 'R' run, 0x53 'S' step, 0x50 'P' pause.
- States: IDLE, LD_LEN_HI, LD_LEN_LO, LD_DATA, RUN, STEP.
- IDLE:
  - 'L' → LD_LEN_HI and clears o_load_overflow.
  - 'R' → RUN and 'S' → STEP, both only when i_halt=0; otherwise ignored.
  - All other bytes ignored.
- LD_LEN_HI / LD_LEN_LO: capture the 16-bit word count N, MSB first.
  - N=0 → IDLE directly with no writes and no o_cpu_reset.
  - Otherwise → LD_DATA with word index 0.
- LD_DATA:
  - Every valid byte is shifted in, MSB first.
  - On the 4th byte of a word, the word is written at addr = index×4 and the index increments.
  - If index ≥ IMEM_WORDS, the write is suppressed and o_load_overflow is set.
  - After word N-1, the state returns to IDLE and o_cpu_reset pulses.
- RUN: o_stall=0.
  - i_halt=1 or a 'P' byte → IDLE; o_stall=1 combinationally in that same cycle.
  - Other bytes are ignored.
- STEP: o_stall=0 for exactly one cycle, then IDLE. Bytes arriving in STEP are dropped.
- o_stall = 1 in every state except RUN (with i_halt=0) and STEP.
- o_cycle_count:
  - Increments (wrapping at 2^32) in every cycle with o_stall=0.
  - Cleared in the cycle o_cpu_reset is asserted.
- o_busy = 1 in LD_LEN_HI, LD_LEN_LO and LD_DATA.

## Timing
- Reset values:
  - State IDLE, o_stall=1, o_imem_write_en=0.
  - o_imem_addr=0, o_imem_data=0, o_cpu_reset=0, o_busy=0.
  - o_load_overflow=0, o_cycle_count=0.
  - Byte counter, word index and length cleared.
- Write latency: o_imem_write_en, o_imem_addr and o_imem_data are registered. They are valid for exactly one cycle, the cycle after the 4th byte's i_rx_valid.
- o_cpu_reset is asserted the cycle after the final write strobe, for one cycle. The state is already IDLE then.
- Command-to-unstall: o_stall falls the cycle after the 'R' or 'S' strobe.
- Reset mid-load: partial word and count are discarded; no write is issued; memory contents already written are retained.
- Back-to-back i_rx_valid on consecutive cycles must be accepted in all LD states with no byte loss.

## Structure
- Package debug_pkg holds:
  - the state encoding (6-state enum)
  - command byte constants CMD_LOAD, CMD_RUN, CMD_STEP, CMD_PAUSE
  - BYTES_PER_WORD=4
- Sub-module word_assembler: 32-bit MSB-first shift register plus 2-bit byte counter. It outputs a word_valid pulse with the assembled word; debug_ctrl clears it on entry to LD_DATA.
- The FSM, word index, length register and cycle counter live in debug_ctrl.

## Test plan
- Reset, then no input → o_stall=1, o_imem_write_en=0, o_cycle_count=0 held indefinitely.
- Load: bytes 4C 00 02 20 08 00 05 AC 01 00 04 → writes 0x20080005 @0x0 and 0xAC010004 @0x4, one cycle each. Then o_cpu_reset pulses once, o_busy falls, and o_cycle_count=0.
- Load with N=0 (4C 00 00) → no write, no o_cpu_reset, back in IDLE.
- Load with IMEM_WORDS=2, N=3 → two writes, third suppressed, o_load_overflow=1. A subsequent 'L' clears it.
- 'S' sent three times → exactly three single-cycle o_stall=0 windows; o_cycle_count=3.
- 'R', then i_halt raised after 10 unstalled cycles:
  - o_stall=1 in the i_halt cycle, o_cycle_count=10, state IDLE.
  - A following 'R' is ignored while i_halt=1.
  - Separately: 'R' then 'P' → stall resumes the cycle of the 'P' strobe.
  - Async reset asserted mid-LD_DATA → IDLE, no write, outputs at reset values.
